// File: rtl/join_match_stage.sv
// join_match_stage: parks the first operand of each tag in a direct-mapped matching memory
// and emits one joined packet (with branch enable exb) when the partner operand arrives.
module join_match_stage #(
   parameter int TAG_W  = 6,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 3
)(
   input  logic              CP,
   input  logic              MR_n,
   input  logic              Send_in,
   output logic              Ack_out,
   input  logic [TAG_W-1:0]  tag_in,
   input  logic              side_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              Send_out,
   input  logic              Ack_in,
   output logic [TAG_W-1:0]  tag_out,
   output logic [DATA_W-1:0] data_l_out,
   output logic [DATA_W-1:0] data_r_out,
   output logic              exb,
   output logic [IDX_W:0]    occ
);
   localparam int DEPTH = 1 << IDX_W;
   logic              vld_q  [DEPTH];
   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic              side_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic              send_q, send_d, exb_q;
   logic [TAG_W-1:0]  tag_out_q;
   logic [DATA_W-1:0] dl_q, dr_q, dl_d, dr_d;
   logic [IDX_W:0]    occ_q, occ_d;
   logic [IDX_W-1:0]  idx;
   logic              hit, empty, out_free, acc, park, mate, pop;
   always_comb begin
      idx      = tag_in[IDX_W-1:0];
      hit      = vld_q[idx] && tag_q[idx] == tag_in && side_q[idx] != side_in;
      empty    = !vld_q[idx];
      out_free = !send_q || Ack_in;
      Ack_out  = MR_n && (empty || (hit && out_free));
      acc      = Send_in && Ack_out;
      park     = acc && empty;
      mate     = acc && hit;
      pop      = send_q && Ack_in;
      // a pop and a new load on the same edge keep Send_out high
      send_d   = mate ? 1'b1 : (pop ? 1'b0 : send_q);
      dl_d     = side_in ? data_q[idx] : data_in;
      dr_d     = side_in ? data_in : data_q[idx];
      occ_d    = occ_q + {{IDX_W{1'b0}}, park} - {{IDX_W{1'b0}}, mate};
   end
   always_ff @(posedge CP or negedge MR_n) begin
      if (!MR_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            vld_q[i]  <= 1'b0;
            tag_q[i]  <= '0;
            side_q[i] <= 1'b0;
            data_q[i] <= '0;
         end
         send_q    <= 1'b0;
         exb_q     <= 1'b0;
         tag_out_q <= '0;
         dl_q      <= '0;
         dr_q      <= '0;
         occ_q     <= '0;
      end else begin
         if (park) begin
            vld_q[idx]  <= 1'b1;
            tag_q[idx]  <= tag_in;
            side_q[idx] <= side_in;
            data_q[idx] <= data_in;
         end
         if (mate) begin
            vld_q[idx] <= 1'b0;
            tag_out_q  <= tag_in;
            dl_q       <= dl_d;
            dr_q       <= dr_d;
            exb_q      <= dl_d != '0;
         end
         send_q <= send_d;
         occ_q  <= occ_d;
      end
   end
   assign Send_out   = send_q;
   assign tag_out    = tag_out_q;
   assign data_l_out = dl_q;
   assign data_r_out = dr_q;
   assign exb        = exb_q;
   assign occ        = occ_q;
endmodule

// File: tb/tb_join_match_stage.sv
// tb_join_match_stage: table-driven directed vectors plus hand-written fill and reset sequences.
module tb_join_match_stage;
   logic        CP = 1'b0, MR_n = 1'b0, Send_in = 1'b0, side_in = 1'b0, Ack_in = 1'b1;
   logic [5:0]  tag_in = '0;
   logic [15:0] data_in = '0;
   logic        Ack_out, Send_out, exb;
   logic [5:0]  tag_out;
   logic [15:0] data_l_out, data_r_out;
   logic [3:0]  occ;
   int total = 0, bad = 0;

   join_match_stage dut (
      .CP(CP), .MR_n(MR_n), .Send_in(Send_in), .Ack_out(Ack_out), .tag_in(tag_in),
      .side_in(side_in), .data_in(data_in), .Send_out(Send_out), .Ack_in(Ack_in),
      .tag_out(tag_out), .data_l_out(data_l_out), .data_r_out(data_r_out), .exb(exb), .occ(occ)
   );

   always #5 CP = ~CP;

   typedef struct {
      logic        snd;
      logic [5:0]  tag;
      logic        side;
      logic [15:0] data;
      logic        ack;
      logic        e_acko;
      logic        e_so;
      logic [5:0]  e_tag;
      logic [15:0] e_dl;
      logic [15:0] e_dr;
      logic        e_exb;
      logic [3:0]  e_occ;
   } vec_t;
   vec_t v [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic snd, input logic [5:0] tag, input logic side,
                        input logic [15:0] data, input logic ack);
      Send_in = snd; tag_in = tag; side_in = side; data_in = data; Ack_in = ack;
   endtask

   task automatic outs(input string name, input logic so, input logic [5:0] t,
                       input logic [15:0] dl, input logic [15:0] dr, input logic e, input logic [3:0] o);
      chk({name, ".Send_out"}, 32'(Send_out), 32'(so));
      chk({name, ".tag_out"}, 32'(tag_out), 32'(t));
      chk({name, ".data_l_out"}, 32'(data_l_out), 32'(dl));
      chk({name, ".data_r_out"}, 32'(data_r_out), 32'(dr));
      chk({name, ".exb"}, 32'(exb), 32'(e));
      chk({name, ".occ"}, 32'(occ), 32'(o));
   endtask

   initial begin
      // step 5 parks tag1, 6 is a same-index conflict, 9-12 exercise backpressure
      v[0]  = '{1, 6'd5, 0, 16'h0003, 1, 1, 0, 6'd0, 16'h0,  16'h0,  0, 4'd1};
      v[1]  = '{1, 6'd5, 1, 16'h0004, 1, 1, 1, 6'd5, 16'h3,  16'h4,  1, 4'd0};
      v[2]  = '{1, 6'd2, 1, 16'h0007, 1, 1, 0, 6'd5, 16'h3,  16'h4,  1, 4'd1};
      v[3]  = '{1, 6'd2, 0, 16'h0000, 1, 1, 1, 6'd2, 16'h0,  16'h7,  0, 4'd0};
      v[4]  = '{1, 6'd1, 0, 16'h0011, 1, 1, 0, 6'd2, 16'h0,  16'h7,  0, 4'd1};
      v[5]  = '{1, 6'd9, 0, 16'h0099, 1, 0, 0, 6'd2, 16'h0,  16'h7,  0, 4'd1};
      v[6]  = '{1, 6'd1, 1, 16'h0022, 1, 1, 1, 6'd1, 16'h11, 16'h22, 1, 4'd0};
      v[7]  = '{1, 6'd9, 0, 16'h0099, 1, 1, 0, 6'd1, 16'h11, 16'h22, 1, 4'd1};
      v[8]  = '{1, 6'd9, 1, 16'h0005, 0, 1, 1, 6'd9, 16'h99, 16'h5,  1, 4'd0};
      v[9]  = '{1, 6'd3, 0, 16'h0030, 0, 1, 1, 6'd9, 16'h99, 16'h5,  1, 4'd1};
      v[10] = '{1, 6'd3, 1, 16'h0031, 0, 0, 1, 6'd9, 16'h99, 16'h5,  1, 4'd1};
      v[11] = '{1, 6'd3, 1, 16'h0031, 1, 1, 1, 6'd3, 16'h30, 16'h31, 1, 4'd0};
      v[12] = '{0, 6'd0, 0, 16'h0000, 1, 1, 0, 6'd3, 16'h30, 16'h31, 1, 4'd0};

      drive(1, 6'd5, 0, 16'h1234, 1);
      #2;
      chk("rst.Ack_out", 32'(Ack_out), 32'd0);
      outs("rst", 0, 6'd0, 16'h0, 16'h0, 0, 4'd0);
      @(negedge CP);
      MR_n = 1'b1;
      drive(0, 6'd0, 0, 16'h0, 1);
      @(posedge CP); #1;

      for (int i = 0; i < 13; i++) begin
         drive(v[i].snd, v[i].tag, v[i].side, v[i].data, v[i].ack);
         #1;
         chk($sformatf("v%0d.Ack_out", i), 32'(Ack_out), 32'(v[i].e_acko));
         @(posedge CP); #1;
         outs($sformatf("v%0d", i), v[i].e_so, v[i].e_tag, v[i].e_dl, v[i].e_dr, v[i].e_exb, v[i].e_occ);
      end

      for (int i = 0; i < 8; i++) begin
         drive(1, 6'(i), 0, 16'(16'h100 + i), 1);
         @(posedge CP); #1;
         chk($sformatf("fill%0d.occ", i), 32'(occ), 32'(i + 1));
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 6'(i), 1, 16'(16'h200 + i), 1);
         #1;
         chk($sformatf("drain%0d.Ack_out", i), 32'(Ack_out), 32'd1);
         @(posedge CP); #1;
         outs($sformatf("drain%0d", i), 1, 6'(i), 16'(16'h100 + i), 16'(16'h200 + i), 1, 4'(7 - i));
      end
      drive(0, 6'd0, 0, 16'h0, 1);
      @(posedge CP); #1;
      chk("drained.Send_out", 32'(Send_out), 32'd0);

      for (int i = 8; i < 12; i++) begin
         drive(1, 6'(i), 0, 16'(i), 1);
         @(posedge CP); #1;
      end
      drive(1, 6'd8, 1, 16'h0080, 0);
      @(posedge CP); #1;
      outs("prerst", 1, 6'd8, 16'h8, 16'h80, 1, 4'd3);
      drive(0, 6'd0, 0, 16'h0, 0);
      #1;
      MR_n = 1'b0;
      #1;
      outs("midrst", 0, 6'd0, 16'h0, 16'h0, 0, 4'd0);
      @(negedge CP);
      MR_n = 1'b1;
      drive(1, 6'd9, 1, 16'h0090, 1);
      @(posedge CP); #1;
      outs("postrst", 0, 6'd0, 16'h0, 16'h0, 0, 4'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
